// File: rtl/ifft_11_point_seq.sv
// Sequential 11-point inverse DFT built on one shared complex MAC.
// Define IFFT_SAT_EN to clamp outputs; otherwise they wrap to WL_OUT bits.
module ifft_11_point_seq #(
  parameter int WL_IN  = 34,
  parameter int WL_OUT = 24,
  parameter int SHIFT  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WL_IN-1:0]  in_r,
  input  logic signed [WL_IN-1:0]  in_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WL_OUT-1:0] out_r,
  output logic signed [WL_OUT-1:0] out_i,
  output logic                     out_last
);

  localparam int AW = WL_IN + 17;

`ifdef IFFT_SAT_EN
  localparam logic signed [AW-1:0] OMAX =
    AW'((longint'(1) <<< (WL_OUT-1)) - longint'(1));
  localparam logic signed [AW-1:0] OMIN = ~OMAX;
`endif

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [3:0] k, n, m;
  logic signed [WL_IN-1:0] fbuf_r [11];
  logic signed [WL_IN-1:0] fbuf_i [11];
  logic signed [AW-1:0] acc_r, acc_i;

  logic signed [11:0] tw_c, tw_s;
  logic signed [AW-1:0] xr, xi, cx, sx;
  logic signed [AW-1:0] sum_r, sum_i;
  logic signed [AW-1:0] sh_r, sh_i;
  logic [4:0] m_sum;
  logic [3:0] m_nx;

  function automatic logic signed [11:0] rom_c(
    input logic [3:0] idx
  );
    case (idx)
      4'd0:    rom_c = 12'sd1024;
      4'd1:    rom_c = 12'sd861;
      4'd2:    rom_c = 12'sd425;
      4'd3:    rom_c = -12'sd146;
      4'd4:    rom_c = -12'sd671;
      4'd5:    rom_c = -12'sd983;
      4'd6:    rom_c = -12'sd983;
      4'd7:    rom_c = -12'sd671;
      4'd8:    rom_c = -12'sd146;
      4'd9:    rom_c = 12'sd425;
      4'd10:   rom_c = 12'sd861;
      default: rom_c = 12'sd0;
    endcase
  endfunction

  function automatic logic signed [11:0] rom_s(
    input logic [3:0] idx
  );
    case (idx)
      4'd0:    rom_s = 12'sd0;
      4'd1:    rom_s = 12'sd554;
      4'd2:    rom_s = 12'sd931;
      4'd3:    rom_s = 12'sd1014;
      4'd4:    rom_s = 12'sd774;
      4'd5:    rom_s = 12'sd288;
      4'd6:    rom_s = -12'sd288;
      4'd7:    rom_s = -12'sd774;
      4'd8:    rom_s = -12'sd1014;
      4'd9:    rom_s = -12'sd931;
      4'd10:   rom_s = -12'sd554;
      default: rom_s = 12'sd0;
    endcase
  endfunction

  function automatic logic signed [WL_OUT-1:0] fit(
    input logic signed [AW-1:0] v
  );
`ifdef IFFT_SAT_EN
    if (v > OMAX)      fit = OMAX[WL_OUT-1:0];
    else if (v < OMIN) fit = OMIN[WL_OUT-1:0];
    else               fit = v[WL_OUT-1:0];
`else
    fit = v[WL_OUT-1:0];
`endif
  endfunction

  // Complex MAC datapath and running twiddle index
  always_comb begin
    tw_c  = rom_c(m);
    tw_s  = rom_s(m);
    xr    = AW'(fbuf_r[k]);
    xi    = AW'(fbuf_i[k]);
    cx    = AW'(tw_c);
    sx    = AW'(tw_s);
    sum_r = acc_r + xr * cx - xi * sx;
    sum_i = acc_i + xr * sx + xi * cx;
    sh_r  = sum_r >>> SHIFT;
    sh_i  = sum_i >>> SHIFT;
    m_sum = {1'b0, m} + {1'b0, n};
    m_nx  = (m_sum >= 5'd11) ? 4'(m_sum - 5'd11)
                             : m_sum[3:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && k == 4'd10) state_nx = CALC;
      end
      CALC: begin
        if (k == 4'd10) state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_last  = (n == 4'd10);
        if (out_ready)
          state_nx = (n == 4'd10) ? LOAD : CALC;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Frame buffer capture; contents are only read after a full frame
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      fbuf_r[k] <= in_r;
      fbuf_i[k] <= in_i;
    end
  end

  // Counters, accumulator and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      n     <= '0;
      m     <= '0;
      acc_r <= '0;
      acc_i <= '0;
      out_r <= '0;
      out_i <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid)
            k <= (k == 4'd10) ? 4'd0 : k + 4'd1;
        end
        CALC: begin
          acc_r <= sum_r;
          acc_i <= sum_i;
          m     <= m_nx;
          if (k == 4'd10) begin
            k     <= 4'd0;
            out_r <= fit(sh_r);
            out_i <= fit(sh_i);
          end else begin
            k <= k + 4'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            acc_r <= '0;
            acc_i <= '0;
            m     <= 4'd0;
            n     <= (n == 4'd10) ? 4'd0 : n + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_11_point_seq.sv
// Scoreboard bench for ifft_11_point_seq.
// Expected samples are queued at issue time and popped by a monitor.
module tb_ifft_11_point_seq;

  localparam int WL_IN  = 34;
  localparam int WL_OUT = 24;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [WL_IN-1:0] in_r;
  logic signed [WL_IN-1:0] in_i;
  logic out_valid;
  logic out_ready;
  logic signed [WL_OUT-1:0] out_r;
  logic signed [WL_OUT-1:0] out_i;
  logic out_last;

  typedef struct {
    longint r;
    longint i;
    bit     last;
  } exp_t;

  exp_t   exp_q[$];
  int     compared;
  int     mismatched;
  int     out_cnt;
  longint fr [11];
  longint fi [11];
  longint hr [11];
  longint hi [11];

  int c_tab [11] = '{1024, 861, 425, -146, -671, -983,
                     -983, -671, -146, 425, 861};
  int s_tab [11] = '{0, 554, 931, 1014, 774, 288,
                     -288, -774, -1014, -931, -554};

  ifft_11_point_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input longint act,
                       input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d",
               name, act, req);
    end
  endtask

  function automatic longint fit(input longint v);
    logic signed [WL_OUT-1:0] w;
`ifdef IFFT_SAT_EN
    if (v > 64'sd8388607)  return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
`endif
    w = v[WL_OUT-1:0];
    return longint'(w);
  endfunction

  // Floor golden model using the rounded twiddle table
  task automatic push_model();
    longint ar, ai;
    int mi;
    exp_t e;
    for (int n = 0; n < 11; n++) begin
      ar = 0;
      ai = 0;
      for (int k = 0; k < 11; k++) begin
        mi = (k * n) % 11;
        ar += fr[k] * c_tab[mi] - fi[k] * s_tab[mi];
        ai += fr[k] * s_tab[mi] + fi[k] * c_tab[mi];
      end
      e.r    = fit(ar >>> 10);
      e.i    = fit(ai >>> 10);
      e.last = (n == 10);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_hand();
    exp_t e;
    for (int n = 0; n < 11; n++) begin
      e.r    = hr[n];
      e.i    = hi[n];
      e.last = (n == 10);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 11; k++) begin
      fr[k] = 0;
      fi[k] = 0;
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 11; k++) begin
      fr[k] = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
      fi[k] = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
    end
  endtask

  task automatic send(input int cnt);
    int w;
    for (int k = 0; k < cnt; k++) begin
      in_valid = 1'b1;
      in_r     = fr[k][WL_IN-1:0];
      in_i     = fi[k][WL_IN-1:0];
      w        = 0;
      while (!in_ready && w < 400) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (!in_ready) begin
        check("in_ready_wait", longint'(in_ready), 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  logic pv, prdy, chk_ir;
  logic signed [WL_OUT-1:0] pr_r, pr_i;

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv      = 1'b0;
      prdy    = 1'b1;
      chk_ir  = 1'b0;
      out_cnt = 0;
    end else begin
      if (chk_ir) begin
        check("in_ready_after_last", longint'(in_ready), 1);
        chk_ir = 1'b0;
      end
      if (pv && !prdy) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_r", out_r, pr_r);
        check("hold_i", out_i, pr_i);
      end
      if (out_valid) begin
        check("in_ready_low", longint'(in_ready), 0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("x%0d_r", out_cnt), out_r, e.r);
            check($sformatf("x%0d_i", out_cnt), out_i, e.i);
            check($sformatf("x%0d_last", out_cnt),
                  longint'(out_last), longint'(e.last));
          end
          out_cnt++;
          if (out_last) begin
            out_cnt = 0;
            chk_ir  = 1'b1;
          end
        end
      end
      pv   = out_valid;
      prdy = out_ready;
      pr_r = out_r;
      pr_i = out_i;
    end
  end

  initial begin
    int w;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_r       = '0;
    in_i       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_i", out_i, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);

    // DC bin
    clear_frame();
    fr[0] = 100;
    for (int n = 0; n < 11; n++) begin
      hr[n] = 100;
      hi[n] = 0;
    end
    push_hand();
    send(11);

    // Single tone on bin 1
    clear_frame();
    fr[1] = 1000;
    hr = '{1000, 840, 415, -143, -656, -960,
           -960, -656, -143, 415, 840};
    hi = '{0, 541, 909, 990, 755, 281,
           -282, -756, -991, -910, -542};
    push_hand();
    send(11);

    // Large DC; rounded cosines sum to -4 over a period
    for (int k = 0; k < 11; k++) begin
      fr[k] = 64'sd1 << 20;
      fi[k] = 0;
    end
`ifdef IFFT_SAT_EN
    hr[0] = 8388607;
`else
    hr[0] = -5242880;
`endif
    hi[0] = 0;
    for (int n = 1; n < 11; n++) begin
      hr[n] = -4096;
      hi[n] = 0;
    end
    push_hand();
    send(11);

    // Backpressure on x[3]
    rand_frame();
    push_model();
    send(11);
    w = 0;
    while (!(out_valid && out_cnt == 3) && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("bp_reach_x3", longint'(out_valid), 1);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset after six accepted samples
    rand_frame();
    send(6);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_out_valid", longint'(out_valid), 0);
    rand_frame();
    push_model();
    send(11);

    // Back-to-back random frames
    rand_frame();
    push_model();
    send(11);
    rand_frame();
    push_model();
    send(11);

    w = 0;
    while (exp_q.size() > 0 && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
